dmem_sequencer: RTL and testbench
=================================

# dmem_sequencer

Run-phase controller and data-memory port arbiter for the pipelined RSA CPU. It loads operands into `data_mem` from a host word stream, then hands the memory port to the processor and holds `start` high until `EndFlag`. It then streams a result window out as bytes over a valid/ready handshake. It sits between `pipelined_processor`, `data_mem` and the host/communication side of `top`.

## Interface
- `LOAD_BASE`, default 32'h0000_0000: byte address of the first loaded word.
- `LOAD_DEPTH`, default 64: maximum words accepted per load phase.
- `DUMP_BASE`, default 32'h0000_0100: byte address of the first result word.
- `DUMP_WORDS`, default 16: result words streamed per dump phase, range 1..255.

Ports:
- `clk` in 1: single system clock (the `clock_manager` output).
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: level-sampled; starts a load phase from IDLE or DONE.
- `host_valid` in 1, `host_data` in 32, `host_last` in 1: load word stream.
- `host_ready` out 1: load stream ready.
- `cpu_start` out 1: drives processor `start`.
- `cpu_end` in 1: processor `EndFlag`.
- `cpu_we` in 1, `cpu_addr` in 32, `cpu_wdata` in 32: processor data-memory port.
- `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32: to `data_mem`.
- `mem_rdata` in 32: `data_mem` ReadData. Synchronous read, valid one cycle after `mem_addr`.
- `out_byte` out 8, `out_valid` out 1, `out_ready` in 1: result byte stream.
- `done` out 1: high in DONE.
- `load_ovf` out 1: sticky; set when a word is offered beyond `LOAD_DEPTH`.

## Operation
- **States:** IDLE, LOAD, RUN, DUMP_RD, DUMP_CAP, DUMP_TX, DONE.
- **IDLE/DONE → LOAD** on `go`=1. Entering LOAD clears the load counter and `load_ovf`.
- **LOAD**
  - `host_ready`=1.
  - Each handshake (`host_valid` & `host_ready`) drives `mem_we`=1, `mem_addr`=`LOAD_BASE`+4·cnt, `mem_wdata`=`host_data`, and increments cnt. These outputs are combinational in the handshake cycle.
  - Transitions to RUN after a handshake with `host_last`=1, or after word `LOAD_DEPTH`-1 is accepted.
  - `host_valid`=0 holds the state.
- **RUN**
  - `cpu_start`=1 (level).
  - The `mem_*` outputs mux directly from the `cpu_*` inputs; `host_ready`=0.
  - `cpu_end`=1 → DUMP_RD. `cpu_end` is ignored in all other states.
- **DUMP_RD:** `mem_addr`=`DUMP_BASE`+4·w, `mem_we`=0, then → DUMP_CAP.
- **DUMP_CAP:** latch `mem_rdata` into the word buffer, set byte index b=0, → DUMP_TX.
- **DUMP_TX**
  - `out_valid`=1; `out_byte`=buffer[8b+7:8b], least-significant byte first.
  - `out_byte` stays stable while `out_ready`=0.
  - On handshake: if b<3, b++; else if w<`DUMP_WORDS`-1, w++ → DUMP_RD; else → DONE.
- **Port ownership:** `mem_we` is 0 whenever the state is not LOAD or RUN. Only the owning side can write.
- **Overflow:** a `host_valid` offered while LOAD is already finishing on word `LOAD_DEPTH`-1 is not possible. Any `host_valid`=1 seen in RUN sets `load_ovf`, and the word is dropped.
- **`go` outside IDLE/DONE** is ignored.
- **Address arithmetic** is 32-bit modulo 2^32, with no saturation.

## Timing
- **Reset** (asynchronous, `reset`=0): state IDLE; all counters 0; every output 0, including `host_ready`, `cpu_start`, `mem_we`, `mem_addr`, `mem_wdata`, `out_valid`, `out_byte`, `done` and `load_ovf`.
- **Reset mid-RUN** drops `cpu_start` immediately (asynchronously).
- **Load rate:** one word per cycle; `host_ready` is high continuously in LOAD.
- **RUN entry:** `cpu_start` rises on the cycle after the final load handshake.
- **`cpu_end` to first byte:** sampled at edge T; DUMP_RD at T+1, DUMP_CAP at T+2, `out_valid` at T+3.
- **Per-word overhead:** 2 idle cycles between the last byte of one word and the first byte of the next. At full rate a word takes 6 cycles.
- **Stall:** an `out_ready` stall of any length holds all state.
- **`done`** rises the cycle after the final byte handshake.

## Structure
- Package `dmem_seq_pkg` holds the state enum `dseq_state_t` and the word/byte stride constants.
- One sub-module, `dmem_port_mux`: a combinational 3-way selector (host load, cpu, dump read) for `mem_we`/`mem_addr`/`mem_wdata`, driven by the state.
- The FSM, counters and byte serializer live in the top of the block.

## Test plan
- **Load 3 words then run:** `go`, then words 0x11111111, 0x22222222 and 0x33333333 (last) → writes at 0x0, 0x4 and 0x8 on consecutive cycles; `cpu_start`=1 on the next cycle.
- **CPU passthrough:** in RUN, `cpu_we`=1, `cpu_addr`=0x40, `cpu_wdata`=0xDEADBEEF → `mem_*` mirror these in the same cycle. Toggling `host_valid` causes no write and sets `load_ovf`.
- **Dump ordering:** memory at 0x100 holds 0xA1B2C3D4, `DUMP_WORDS`=2 → bytes D4, C3, B2, A1, then the word at 0x104. `done` rises after byte 8; first `out_valid` at `cpu_end`+3.
- **Backpressure:** hold `out_ready`=0 for 5 cycles mid-word → `out_byte` stays constant, no byte is skipped or repeated, and the total byte count is exactly 4·`DUMP_WORDS`.
- **Depth limit:** `LOAD_DEPTH`=4 with 6 words offered and no `host_last` → 4 writes; RUN is entered after the 4th word; `load_ovf`=1.
- **Reset mid-dump:** assert `reset`=0 during DUMP_TX → all outputs 0 immediately. After release, `go` starts a fresh LOAD at `LOAD_BASE`.

Source files
------------

// File: rtl/dmem_seq_pkg.sv
// Shared types and constants for the dmem_sequencer run-phase controller.
package dmem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_CAP,
    S_DUMP_TX,
    S_DONE
  } dseq_state_t;

  // Which side currently owns the data-memory port.
  typedef enum logic [1:0] {
    PSEL_NONE,
    PSEL_HOST,
    PSEL_CPU,
    PSEL_DUMP
  } port_sel_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;
  localparam int unsigned BYTE_W      = 8;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational data-memory port selector: host load, processor, or dump read.
module dmem_port_mux
  import dmem_seq_pkg::*;
(
  input  port_sel_t   sel,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] dump_addr,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata
);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (sel)
      PSEL_HOST: begin
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      PSEL_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      PSEL_DUMP: mem_addr = dump_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_sequencer.sv
// Load / run / dump controller that owns the data-memory port and serializes
// a result window out as bytes.
module dmem_sequencer
  import dmem_seq_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE  = 32'h0000_0000,
  parameter int unsigned LOAD_DEPTH = 64,
  parameter logic [31:0] DUMP_BASE  = 32'h0000_0100,
  parameter int unsigned DUMP_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  input  logic        host_last,
  output logic        host_ready,
  output logic        cpu_start,
  input  logic        cpu_end,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        load_ovf
);

  localparam logic [31:0] LOAD_LAST = 32'(LOAD_DEPTH - 1);
  localparam logic [7:0]  DUMP_LAST = 8'(DUMP_WORDS - 1);

  dseq_state_t state;
  port_sel_t   sel;
  logic [31:0] load_cnt;
  logic [7:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [1:0]  byte_nxt;
  logic [31:0] word_buf;
  logic        host_hs;
  logic [31:0] load_addr;
  logic [31:0] dump_addr;

  // host_ready is a registered copy of (state == S_LOAD), so it doubles as the
  // handshake qualifier without adding a decode path.
  assign host_hs   = host_valid & host_ready;
  assign load_addr = LOAD_BASE + load_cnt * WORD_STRIDE;
  assign dump_addr = DUMP_BASE + 32'(word_idx) * WORD_STRIDE;
  assign byte_nxt  = byte_idx + 2'd1;

  always_comb begin
    sel = PSEL_NONE;
    case (state)
      S_LOAD:    sel = PSEL_HOST;
      S_RUN:     sel = PSEL_CPU;
      S_DUMP_RD: sel = PSEL_DUMP;
      default:   sel = PSEL_NONE;
    endcase
  end

  dmem_port_mux u_port_mux (
    .sel        (sel),
    .host_we    (host_hs),
    .host_addr  (load_addr),
    .host_wdata (host_data),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .dump_addr  (dump_addr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      load_cnt   <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      host_ready <= 1'b0;
      cpu_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_byte   <= '0;
      done       <= 1'b0;
      load_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state      <= S_LOAD;
            load_cnt   <= '0;
            load_ovf   <= 1'b0;
            host_ready <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (host_hs) begin
            load_cnt <= load_cnt + 32'd1;
            if (host_last || (load_cnt == LOAD_LAST)) begin
              state      <= S_RUN;
              host_ready <= 1'b0;
              cpu_start  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (host_valid) load_ovf <= 1'b1;
          if (cpu_end) begin
            state     <= S_DUMP_RD;
            cpu_start <= 1'b0;
            word_idx  <= '0;
          end
        end
        S_DUMP_RD: state <= S_DUMP_CAP;
        S_DUMP_CAP: begin
          word_buf  <= mem_rdata;
          out_byte  <= mem_rdata[BYTE_W-1:0];
          byte_idx  <= '0;
          out_valid <= 1'b1;
          state     <= S_DUMP_TX;
        end
        S_DUMP_TX: begin
          if (out_ready) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_nxt;
              out_byte <= word_buf[{byte_nxt, 3'b000} +: BYTE_W];
            end else begin
              out_valid <= 1'b0;
              if (word_idx != DUMP_LAST) begin
                word_idx <= word_idx + 8'd1;
                state    <= S_DUMP_RD;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// Directed bench for dmem_sequencer with a small synchronous-read memory model.
module tb_dmem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_last;
  logic        host_ready;
  logic        cpu_start;
  logic        cpu_end;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        load_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nbytes = 0;

  logic [31:0] mem [0:127];

  always #5 clk = ~clk;

  dmem_sequencer #(
    .LOAD_BASE  (32'h0000_0000),
    .LOAD_DEPTH (4),
    .DUMP_BASE  (32'h0000_0100),
    .DUMP_WORDS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_last  (host_last),
    .host_ready (host_ready),
    .cpu_start  (cpu_start),
    .cpu_end    (cpu_end),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done),
    .load_ovf   (load_ovf)
  );

  always @(posedge clk) begin
    if (!reset) begin
      mem[64] <= 32'hA1B2_C3D4;
      mem[65] <= 32'h5566_7788;
    end else if (mem_we) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[8:2]];
  end

  always @(posedge clk)
    if (reset && out_valid && out_ready) nbytes <= nbytes + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    check({tag, "_cpu_start"},  32'(cpu_start),  32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_addr"},   mem_addr,        32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    check({tag, "_out_valid"},  32'(out_valid),  32'd0);
    check({tag, "_out_byte"},   32'(out_byte),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_load_ovf"},   32'(load_ovf),   32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; go = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
    cpu_end = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    cyc(); cyc();
    reset = 1'b1;

    // Load three words, last one flagged.
    go = 1'b1;
    cyc();
    go = 1'b0;
    check("load_host_ready", 32'(host_ready), 32'd1);
    host_valid = 1'b1; host_data = 32'h1111_1111; #1;
    check("load0_we", 32'(mem_we), 32'd1);
    check("load0_addr", mem_addr, 32'h0);
    check("load0_data", mem_wdata, 32'h1111_1111);
    cyc();
    host_data = 32'h2222_2222; #1;
    check("load1_addr", mem_addr, 32'h4);
    check("load1_data", mem_wdata, 32'h2222_2222);
    cyc();
    host_data = 32'h3333_3333; host_last = 1'b1; #1;
    check("load2_we", 32'(mem_we), 32'd1);
    check("load2_addr", mem_addr, 32'h8);
    check("load2_start_low", 32'(cpu_start), 32'd0);
    cyc();
    host_valid = 1'b0; host_last = 1'b0; #1;
    check("run_cpu_start", 32'(cpu_start), 32'd1);
    check("run_host_ready", 32'(host_ready), 32'd0);
    check("mem_word2", mem[2], 32'h3333_3333);

    // Processor passthrough and overflow on stray host words.
    cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF; #1;
    check("cpu_we", 32'(mem_we), 32'd1);
    check("cpu_addr", mem_addr, 32'h40);
    check("cpu_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("ovf_before", 32'(load_ovf), 32'd0);
    cpu_we = 1'b0; host_valid = 1'b1; host_data = 32'h9999_9999; #1;
    check("host_in_run_we", 32'(mem_we), 32'd0);
    check("host_in_run_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    host_valid = 1'b0; #1;
    check("ovf_set", 32'(load_ovf), 32'd1);

    // Dump two words with a 5-cycle stall inside the second word.
    cpu_end = 1'b1;
    cyc();
    cpu_end = 1'b0; #1;
    check("rd_addr0", mem_addr, 32'h100);
    check("rd_we0", 32'(mem_we), 32'd0);
    check("rd_valid0", 32'(out_valid), 32'd0);
    check("rd_cpu_start", 32'(cpu_start), 32'd0);
    cyc();
    check("cap_valid0", 32'(out_valid), 32'd0);
    cyc();
    check("first_valid", 32'(out_valid), 32'd1);
    check("b0", 32'(out_byte), 32'hD4);
    out_ready = 1'b1;
    cyc(); check("b1", 32'(out_byte), 32'hC3);
    cyc(); check("b2", 32'(out_byte), 32'hB2);
    cyc(); check("b3", 32'(out_byte), 32'hA1);
    cyc();
    check("gap_valid_rd", 32'(out_valid), 32'd0);
    check("rd_addr1", mem_addr, 32'h104);
    cyc();
    check("gap_valid_cap", 32'(out_valid), 32'd0);
    cyc(); check("b4", 32'(out_byte), 32'h88);
    check("b4_valid", 32'(out_valid), 32'd1);
    cyc(); check("b5", 32'(out_byte), 32'h77);
    cyc(); check("b6", 32'(out_byte), 32'h66);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("stall_byte", 32'(out_byte), 32'h66);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    cyc(); check("b7", 32'(out_byte), 32'h55);
    check("b7_done_low", 32'(done), 32'd0);
    cyc();
    check("done", 32'(done), 32'd1);
    check("done_valid", 32'(out_valid), 32'd0);
    cyc();
    check("byte_count", nbytes, 32'd8);
    out_ready = 1'b0;

    // Depth limit: six words offered, only four accepted.
    go = 1'b1;
    cyc();
    go = 1'b0;
    check("depth_ovf_cleared", 32'(load_ovf), 32'd0);
    check("depth_done_cleared", 32'(done), 32'd0);
    host_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      host_data = 32'hA0 + 32'(i); #1;
      check("depth_we", 32'(mem_we), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) check("depth_addr", mem_addr, 32'(i) * 32'd4);
      cyc();
    end
    host_valid = 1'b0; #1;
    check("depth_ovf", 32'(load_ovf), 32'd1);
    check("depth_cpu_start", 32'(cpu_start), 32'd1);
    check("depth_mem3", mem[3], 32'hA3);

    // Reset in the middle of a dump.
    cpu_end = 1'b1;
    cyc();
    cpu_end = 1'b0;
    cyc(); cyc();
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_byte", 32'(out_byte), 32'hD4);
    #2 reset = 1'b0; #1;
    check_all_zero("midreset");
    cyc();
    reset = 1'b1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    host_valid = 1'b1; host_data = 32'h0000_0077; host_last = 1'b1; #1;
    check("reload_addr", mem_addr, 32'h0);
    check("reload_we", 32'(mem_we), 32'd1);
    cyc();
    host_valid = 1'b0; host_last = 1'b0; #1;
    check("reload_run", 32'(cpu_start), 32'd1);
    #2 reset = 1'b0; #1;
    check("run_reset_start", 32'(cpu_start), 32'd0);
    cyc();
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
